// File: rtl/symbol_histogram_if.sv
// Symbol stream, coder handshake and leaf descriptor bundle for symbol_histogram.
// The slave modport is the histogram block; the master modport is its environment.
interface symbol_histogram_if;
  logic        sym_valid;
  logic        sym_ready;
  logic [3:0]  sym_data;
  logic        sym_last;
  logic [18:0] data_out0;
  logic [18:0] data_out1;
  logic [18:0] data_out2;
  logic [18:0] data_out3;
  logic [18:0] data_out4;
  logic [18:0] data_out5;
  logic [18:0] data_out6;
  logic [18:0] data_out7;
  logic [18:0] data_out8;
  logic [18:0] data_out9;
  logic        req_coding;
  logic        ack_coding;
  logic        trans_start;
  logic        bad_sym;
  logic        busy;

  modport slave (
    input  sym_valid, sym_data, sym_last, ack_coding, trans_start,
    output sym_ready, req_coding, bad_sym, busy,
    output data_out0, data_out1, data_out2, data_out3, data_out4,
    output data_out5, data_out6, data_out7, data_out8, data_out9
  );

  modport master (
    output sym_valid, sym_data, sym_last, ack_coding, trans_start,
    input  sym_ready, req_coding, bad_sym, busy,
    input  data_out0, data_out1, data_out2, data_out3, data_out4,
    input  data_out5, data_out6, data_out7, data_out8, data_out9
  );
endinterface

// File: rtl/symbol_histogram.sv
// Counts symbols 0..9 of one block into saturating 8-bit bins, then hands the
// frozen counts to the Huffman coder and clears them once the coder is done.
module symbol_histogram #(
  parameter int CNT_MAX = 254
) (
  input  logic               clk,
  input  logic               rst,
  symbol_histogram_if.slave  bus
);

  typedef enum logic [2:0] {ACCUM, REQ, WAIT_TX, DRAIN, CLEAR} state_t;

  localparam logic [7:0] CntMax = 8'(CNT_MAX);

  state_t     state_q, state_d;
  logic [7:0] cnt_q [10];
  logic [7:0] cnt_d [10];
  logic       bad_q, bad_d;
  logic       req_q, req_d;
  logic       accept;

  assign accept = bus.sym_valid && (state_q == ACCUM);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bad_d   = bad_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (bus.sym_data <= 4'd9) begin
            if (cnt_q[bus.sym_data] < CntMax) begin
              cnt_d[bus.sym_data] = cnt_q[bus.sym_data] + 8'd1;
            end
          end else begin
            bad_d = 1'b1;
          end
          if (bus.sym_last) state_d = REQ;
        end
      end
      REQ:     if (bus.ack_coding)   state_d = WAIT_TX;
      WAIT_TX: if (bus.trans_start)  state_d = DRAIN;
      DRAIN:   if (!bus.trans_start) state_d = CLEAR;
      CLEAR: begin
        state_d = ACCUM;
        cnt_d   = '{default: '0};
        bad_d   = 1'b0;
      end
      default: state_d = ACCUM;
    endcase
    // Registered from the next state so it drops on the same edge that samples ack.
    req_d = (state_d == REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      cnt_q   <= '{default: '0};
      bad_q   <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bad_q   <= bad_d;
      req_q   <= req_d;
    end
  end

  assign bus.sym_ready  = (state_q == ACCUM);
  assign bus.busy       = (state_q != ACCUM);
  assign bus.req_coding = req_q;
  assign bus.bad_sym    = bad_q;

  assign bus.data_out0 = {6'b0, 5'd0, cnt_q[0]};
  assign bus.data_out1 = {6'b0, 5'd1, cnt_q[1]};
  assign bus.data_out2 = {6'b0, 5'd2, cnt_q[2]};
  assign bus.data_out3 = {6'b0, 5'd3, cnt_q[3]};
  assign bus.data_out4 = {6'b0, 5'd4, cnt_q[4]};
  assign bus.data_out5 = {6'b0, 5'd5, cnt_q[5]};
  assign bus.data_out6 = {6'b0, 5'd6, cnt_q[6]};
  assign bus.data_out7 = {6'b0, 5'd7, cnt_q[7]};
  assign bus.data_out8 = {6'b0, 5'd8, cnt_q[8]};
  assign bus.data_out9 = {6'b0, 5'd9, cnt_q[9]};

endmodule

// File: tb/tb_symbol_histogram.sv
// Directed and randomized bench for symbol_histogram against a plain count model.
module tb_symbol_histogram;
  logic clk;
  logic rst;
  int   testsRun;
  int   testsFailed;
  int   modelCnt [10];
  bit   modelBad;

  symbol_histogram_if bus ();

  symbol_histogram #(.CNT_MAX(254)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [18:0] getOut(input int n);
    case (n)
      0: return bus.data_out0;
      1: return bus.data_out1;
      2: return bus.data_out2;
      3: return bus.data_out3;
      4: return bus.data_out4;
      5: return bus.data_out5;
      6: return bus.data_out6;
      7: return bus.data_out7;
      8: return bus.data_out8;
      default: return bus.data_out9;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkCounts(input string tag);
    for (int n = 0; n < 10; n++) begin
      checkOutput($sformatf("%s out%0d", tag, n), {13'b0, getOut(n)},
                  {13'b0, 6'b0, 5'(n), 8'(modelCnt[n])});
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Present one symbol for exactly one cycle while the block is accepting.
  task automatic applyStimulus(input logic [3:0] d, input logic last);
    bus.sym_valid = 1'b1;
    bus.sym_data  = d;
    bus.sym_last  = last;
    cycle();
    bus.sym_valid = 1'b0;
    bus.sym_last  = 1'b0;
    if (d <= 4'd9) begin
      if (modelCnt[d] < 254) modelCnt[d]++;
    end else begin
      modelBad = 1'b1;
    end
  endtask

  // Coder handshake, entered right after the edge that accepted sym_last.
  task automatic runHandshake(input string tag);
    checkOutput({tag, " req rise"}, 32'(bus.req_coding), 32'd1);
    checkOutput({tag, " busy req"}, 32'(bus.busy), 32'd1);
    checkOutput({tag, " ready req"}, 32'(bus.sym_ready), 32'd0);
    bus.sym_valid   = 1'b1;
    bus.sym_data    = 4'($urandom_range(0, 9));
    bus.trans_start = 1'b1;
    cycle();
    bus.trans_start = 1'b0;
    checkOutput({tag, " req hold"}, 32'(bus.req_coding), 32'd1);
    bus.ack_coding = 1'b1;
    cycle();
    bus.ack_coding = 1'b0;
    checkOutput({tag, " req drop"}, 32'(bus.req_coding), 32'd0);
    checkOutput({tag, " busy wait"}, 32'(bus.busy), 32'd1);
    bus.trans_start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.sym_data = 4'($urandom_range(0, 9));
      cycle();
      if (i == 10) checkCounts({tag, " mid tx"});
    end
    checkOutput({tag, " busy tx"}, 32'(bus.busy), 32'd1);
    bus.trans_start = 1'b0;
    cycle();
    checkOutput({tag, " busy clear"}, 32'(bus.busy), 32'd1);
    checkOutput({tag, " ready clear"}, 32'(bus.sym_ready), 32'd0);
    checkCounts({tag, " before clear"});
    bus.sym_valid = 1'b0;
    cycle();
    modelCnt = '{default: 0};
    modelBad = 1'b0;
    checkCounts({tag, " cleared"});
    checkOutput({tag, " ready back"}, 32'(bus.sym_ready), 32'd1);
    checkOutput({tag, " busy back"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, " bad cleared"}, 32'(bus.bad_sym), 32'd0);
  endtask

  initial begin
    int len;
    testsRun        = 0;
    testsFailed     = 0;
    modelCnt        = '{default: 0};
    modelBad        = 1'b0;
    rst             = 1'b1;
    bus.sym_valid   = 1'b0;
    bus.sym_data    = 4'd0;
    bus.sym_last    = 1'b0;
    bus.ack_coding  = 1'b0;
    bus.trans_start = 1'b0;
    repeat (2) cycle();
    rst = 1'b0;

    checkCounts("reset");
    checkOutput("reset req", 32'(bus.req_coding), 32'd0);
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset ready", 32'(bus.sym_ready), 32'd1);
    checkOutput("reset bad", 32'(bus.bad_sym), 32'd0);

    // Stray coder strobes while accumulating must not move the FSM.
    bus.ack_coding  = 1'b1;
    bus.trans_start = 1'b1;
    cycle();
    bus.ack_coding  = 1'b0;
    bus.trans_start = 1'b0;
    checkOutput("stray busy", 32'(bus.busy), 32'd0);
    checkOutput("stray ready", 32'(bus.sym_ready), 32'd1);

    applyStimulus(4'd3, 1'b0);
    applyStimulus(4'd3, 1'b0);
    applyStimulus(4'd7, 1'b0);
    applyStimulus(4'd0, 1'b1);
    checkOutput("basic out3", 32'(bus.data_out3), 32'({6'b0, 5'd3, 8'd2}));
    checkCounts("basic");
    runHandshake("basic");

    for (int b = 0; b < 4; b++) begin
      len = int'($urandom_range(1, 30));
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 2)) cycle();
        applyStimulus(4'($urandom_range(0, 11)), i == len - 1);
      end
      checkCounts($sformatf("rand%0d", b));
      checkOutput($sformatf("rand%0d bad", b), 32'(bus.bad_sym), 32'(modelBad));
      runHandshake($sformatf("rand%0d", b));
    end

    for (int i = 0; i < 300; i++) begin
      applyStimulus(4'd5, i == 299);
      if (i == 253 || i == 254) checkCounts($sformatf("sat %0d", i + 1));
    end
    checkOutput("sat final", 32'(bus.data_out5[7:0]), 32'd254);
    runHandshake("sat");

    applyStimulus(4'd12, 1'b0);
    checkOutput("bad set", 32'(bus.bad_sym), 32'd1);
    applyStimulus(4'd2, 1'b1);
    checkOutput("bad out2", 32'(bus.data_out2), 32'({6'b0, 5'd2, 8'd1}));
    checkCounts("bad");
    runHandshake("bad");

    applyStimulus(4'd13, 1'b1);
    checkCounts("empty");
    checkOutput("empty bad", 32'(bus.bad_sym), 32'd1);
    runHandshake("empty");

    // Reset while in WAIT_TX with the symbol input hammering.
    applyStimulus(4'd4, 1'b0);
    applyStimulus(4'd9, 1'b1);
    cycle();
    bus.ack_coding = 1'b1;
    cycle();
    bus.ack_coding = 1'b0;
    bus.sym_valid  = 1'b1;
    bus.sym_data   = 4'd4;
    repeat (5) cycle();
    checkCounts("wait hold");
    checkOutput("wait busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    cycle();
    rst           = 1'b0;
    bus.sym_valid = 1'b0;
    modelCnt      = '{default: 0};
    modelBad      = 1'b0;
    checkCounts("rst wait");
    checkOutput("rst wait req", 32'(bus.req_coding), 32'd0);
    checkOutput("rst wait ready", 32'(bus.sym_ready), 32'd1);
    checkOutput("rst wait busy", 32'(bus.busy), 32'd0);

    // Reset while requesting drops req on the same edge.
    applyStimulus(4'd1, 1'b1);
    checkOutput("rst req pre", 32'(bus.req_coding), 32'd1);
    rst = 1'b1;
    cycle();
    rst      = 1'b0;
    modelCnt = '{default: 0};
    checkOutput("rst req drop", 32'(bus.req_coding), 32'd0);
    checkCounts("rst req");
    applyStimulus(4'd6, 1'b0);
    checkCounts("after rst");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule

// File: doc/symbol_histogram.md
SYMBOL_HISTOGRAM -- requirements
Module: symbol_histogram

Interface
REQ-001 Parameter: CNT_MAX, 254, saturation ceiling of each 8-bit symbol count; it stays below the coder's 255 sort-pad value.
REQ-002 Port: clk  in  1  single clock, all logic on rising edge.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: sym_valid  in  1  input symbol present.
REQ-005 Port: sym_ready  out  1  block accepts a symbol this cycle.
REQ-006 Port: sym_data  in  4  symbol value; legal range 0..9.
REQ-007 Port: sym_last  in  1  the accepted symbol is the final one of the block.
REQ-008 Port: data_out0..data_out9  out  19 each  packed leaf descriptors {6'b0, 5'dN, cnt_N[7:0]} for N = 0..9.
REQ-009 Port: req_coding  out  1  request to the Huffman coder.
REQ-010 Port: ack_coding  in  1  coder acknowledge.
REQ-011 Port: trans_start  in  1  coder code-output phase active.
REQ-012 Port: bad_sym  out  1  sticky flag: an out-of-range symbol was received.
REQ-013 Port: busy  out  1  high in every state except ACCUM.

Function
REQ-014 FSM states: ACCUM, REQ, WAIT_TX, DRAIN, CLEAR.
REQ-015 State behaviour:
- sym_ready = 1 only in ACCUM.
- A symbol is accepted on a cycle with sym_valid & sym_ready.
REQ-016 ACCUM, accepted sym_data <= 9: cnt[sym_data] increments by 1 on the next edge, saturating at CNT_MAX.
REQ-017 ACCUM, accepted sym_data > 9: no count changes; bad_sym sets to 1 on the next edge.
REQ-018 ACCUM, accepted symbol with sym_last = 1: the symbol is counted per REQ-016/017 and the state moves to REQ.
REQ-019 ACCUM with sym_valid = 0: state and counts hold.
REQ-020 REQ: req_coding = 1 for the whole state.
- If ack_coding = 1 is sampled, the next state is WAIT_TX.
- req_coding is registered low on that same edge, so it is never high for more than one cycle after ack.
REQ-021 WAIT_TX: stays until trans_start = 1 is sampled, then moves to DRAIN.
REQ-022 DRAIN: stays until trans_start = 0 is sampled, then moves to CLEAR.
REQ-023 CLEAR: lasts one cycle.
- All cnt_N go to 0.
- bad_sym clears.
- The next state is ACCUM.
REQ-024 data_out0..9 are driven directly from the count registers.
- They hold stable from leaving ACCUM until CLEAR.
- They are never modified while req_coding or trans_start is high.
REQ-025 Index field 5'dN is constant per port. The upper 6 bits are always 0.
REQ-026 Empty block: a block whose only accepted symbols are invalid still runs REQ..CLEAR with all counts 0.
REQ-027 A count at CNT_MAX stays at CNT_MAX on further hits. No wrap.
REQ-028 sym_valid is ignored outside ACCUM. No symbol is lost or counted while busy = 1.
REQ-029 ack_coding or trans_start pulses outside their waiting states are ignored.

Reset
REQ-030 rst = 1 on a clock edge forces, on that edge, regardless of state:
- state ACCUM;
- all cnt_N 0, so data_outN = {6'b0, 5'dN, 8'd0};
- req_coding 0, bad_sym 0, busy 0, sym_ready 1 on the following cycle.
REQ-031 Reset mid-request (state REQ or later) drops req_coding on that same edge and abandons the block.

Verification
REQ-032 Stream 3,3,7,0 with last on the 0 -> data_out3 = {6'b0,5'd3,8'd2}, data_out7 = …8'd1, data_out0 = …8'd1, others 0; req_coding rises the cycle after last.
REQ-033 Handshake sequence:
- Stimulus: ack_coding asserted 1 cycle after req_coding; trans_start high for 20 cycles then low.
- Response: req_coding low the cycle after ack; busy high throughout; counts cleared one cycle after trans_start falls; sym_ready returns the cycle after CLEAR.
REQ-034 300 consecutive symbol-5 followed by last -> data_out5[7:0] = 254 (CNT_MAX), no wrap.
REQ-035 Symbols 12, 2 with last on the 2 -> bad_sym = 1, data_out2[7:0] = 1, no other count changes; bad_sym clears in CLEAR.
REQ-036 Reset scenario:
- Stimulus: rst asserted while in WAIT_TX, with sym_valid held high during busy.
- Response: no count changes while busy; after reset, all counts 0, req_coding 0, sym_ready 1, state ACCUM.
